word_serializer: RTL and testbench

//  Converts a WIDTH-bit parallel word into a bit-serial stream, one bit per accepted beat.

---
 rtl/word_serializer.sv | 135 +++++++++++++
 tb/tb_word_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Purpose : parallel WIDTH-bit word to bit-serial stream, one bit per out beat (optional even-parity tail beat).
// Latency : word accepted at edge N -> first bit valid right after edge N; back-to-back words have no idle gap.
// Backpr. : out_ready=0 freezes shift reg, count and all serial outputs; in_ready only rises on IDLE or final beat.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready     parallel word handshake; in_data sampled when both are high
//   in_data[WIDTH-1:0]    parallel word
//   out_valid/out_ready   serial beat handshake
//   out_bit               current serial bit
//   out_first/out_last    first / final beat of a word (final = parity beat when parity is built in)
//   busy                  a word is loaded and not yet fully shifted out
//
// Build option: define SERIALIZER_PARITY_EN to append one even-parity beat (XOR of the word)
// after the WIDTH data bits. Without it no parity logic exists.

module word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif
    localparam int BEATS = WIDTH + PAR_BEATS;
    localparam int CW    = $clog2(WIDTH + 2);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_count;
    logic             r_first;
    logic             r_valid;
    logic             r_init;   // keeps in_ready low until the first clock after reset release

    logic             w_beat;
    logic             w_last;
    logic             w_fin;
    logic             w_load;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;

    assign w_beat = r_valid & out_ready;
    assign w_last = r_valid & (r_count == CW'(1));
    assign w_fin  = w_beat & w_last;

    // Accept when idle, or on the final beat so the next word follows with no gap.
    assign in_ready = r_init & ((r_state == S_IDLE) | w_fin);
    assign w_load   = in_valid & in_ready;

`ifdef SERIALIZER_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^in_data;
        end
    end

    // The parity bit is shifted in behind the data; the first fill bit reaches the
    // output position exactly after WIDTH shifts, i.e. on the extra beat.
    assign w_fill = r_par;
`else
    assign w_fill = 1'b0;
`endif

    always_comb begin
        w_shifted = '0;
        if (MSB_FIRST) begin
            w_shifted = (r_sreg << 1) | WIDTH'(w_fill);
        end else begin
            w_shifted = (r_sreg >> 1) | (WIDTH'(w_fill) << (WIDTH - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_count <= '0;
            r_first <= 1'b0;
            r_valid <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (w_load) begin
                // Covers both IDLE->SHIFT and reload on the final beat.
                r_state <= S_SHIFT;
                r_sreg  <= in_data;
                r_count <= CW'(BEATS);
                r_first <= 1'b1;
                r_valid <= 1'b1;
            end else if (w_beat) begin
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_sreg  <= '0;
                    r_count <= '0;
                    r_first <= 1'b0;
                    r_valid <= 1'b0;
                end else begin
                    r_sreg  <= w_shifted;
                    r_count <= r_count - CW'(1);
                    r_first <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_bit   = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign out_first = r_first;
    assign out_last  = w_last;
    assign busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_word_serializer.sv
// Purpose : directed checks of word_serializer (8-bit MSB-first, 8-bit LSB-first, 1-bit instances).
// Latency : inputs driven 1 time unit after each rising edge; outputs sampled at that same point.
// Backpr. : out_ready pattern 1,0,0,1 applied to the MSB-first instance for one word.

module tb_word_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int B8 = 8 + PAR;
    localparam int B1 = 1 + PAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit MSB-first instance
    logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic       m_out_bit, m_out_first, m_out_last, m_busy;
    logic [7:0] m_in_data;
    // 8-bit LSB-first instance
    logic       l_in_valid, l_in_ready, l_out_valid, l_out_ready;
    logic       l_out_bit, l_out_first, l_out_last, l_busy;
    logic [7:0] l_in_data;
    // 1-bit instance
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic       s_out_bit, s_out_first, s_out_last, s_busy;
    logic [0:0] s_in_data;

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_bit(m_out_bit),
        .out_first(m_out_first), .out_last(m_out_last), .busy(m_busy)
    );

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_bit(l_out_bit),
        .out_first(l_out_first), .out_last(l_out_last), .busy(l_busy)
    );

    word_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_bit(s_out_bit),
        .out_first(s_out_first), .out_last(s_out_last), .busy(s_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial bit i of an 8-bit word; index 8 is the even-parity beat.
    function automatic logic ebit(input logic [7:0] d, input int i, input bit msb);
        if (i >= 8) return ^d;
        return msb ? d[7-i] : d[i];
    endfunction

    // Checks one full word on the MSB-first instance with out_ready=1; clears in_valid
    // after the final edge (a held next word is taken on that edge).
    task automatic check_word_m(input logic [7:0] d, input string tag);
        for (int i = 0; i < B8; i++) begin
            chk({tag, " valid"}, m_out_valid, 1'b1);
            chk({tag, " bit"},   m_out_bit,   ebit(d, i, 1'b1));
            chk({tag, " first"}, m_out_first, (i == 0));
            chk({tag, " last"},  m_out_last,  (i == B8 - 1));
            chk({tag, " rdy"},   m_in_ready,  (i == B8 - 1));
            chk({tag, " busy"},  m_busy,      1'b1);
            tick();
        end
        m_in_valid = 1'b0;
    endtask

    initial begin : stim
        logic [3:0] pat;
        logic       ordy;
        logic       prev_bit;
        logic       prev_stall;
        int         b;
        int         c;

        rst_n = 1'b0;
        m_in_valid = 1'b0; m_in_data = 8'h00; m_out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_data = 8'h00; l_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = 1'b0;  s_out_ready = 1'b1;

        // ---- reset state ----
        #2;
        chk("rst in_ready",  m_in_ready,  1'b0);
        chk("rst out_valid", m_out_valid, 1'b0);
        chk("rst out_bit",   m_out_bit,   1'b0);
        chk("rst out_first", m_out_first, 1'b0);
        chk("rst out_last",  m_out_last,  1'b0);
        chk("rst busy",      m_busy,      1'b0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("rel m in_ready",  m_in_ready,  1'b1);
        chk("rel m out_valid", m_out_valid, 1'b0);
        chk("rel l in_ready",  l_in_ready,  1'b1);
        chk("rel s in_ready",  s_in_ready,  1'b1);

        // ---- 8'hA5 MSB first: 1,0,1,0,0,1,0,1 (+ parity 0) ----
        m_in_data = 8'hA5; m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        check_word_m(8'hA5, "a5");
        chk("a5 idle valid", m_out_valid, 1'b0);
        chk("a5 idle busy",  m_busy,      1'b0);
        chk("a5 idle rdy",   m_in_ready,  1'b1);

        // ---- 8'h01 LSB first: 1,0,0,0,0,0,0,0 (+ parity 1) ----
        l_in_data = 8'h01; l_in_valid = 1'b1;
        tick();
        l_in_valid = 1'b0;
        for (int i = 0; i < B8; i++) begin
            chk("lsb valid", l_out_valid, 1'b1);
            chk("lsb bit",   l_out_bit,   ebit(8'h01, i, 1'b0));
            chk("lsb first", l_out_first, (i == 0));
            chk("lsb last",  l_out_last,  (i == B8 - 1));
            tick();
        end
        chk("lsb idle valid", l_out_valid, 1'b0);
        chk("lsb idle busy",  l_busy,      1'b0);

        // ---- back-to-back 8'hFF then 8'h00, in_valid held ----
        m_in_data = 8'hFF; m_in_valid = 1'b1;
        tick();
        m_in_data = 8'h00;
        check_word_m(8'hFF, "b2b ff");
        check_word_m(8'h00, "b2b 00");
        chk("b2b idle valid", m_out_valid, 1'b0);
        chk("b2b idle rdy",   m_in_ready,  1'b1);

        // ---- backpressure on 8'h3C with out_ready 1,0,0,1,... ----
        pat = 4'b1001;
        m_in_data = 8'h3C; m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        b = 0;
        c = 0;
        prev_bit = 1'b0;
        prev_stall = 1'b0;
        while (b < B8 && c < 64) begin
            ordy = pat[c % 4];
            m_out_ready = ordy;
            #1;
            chk("bp valid", m_out_valid, 1'b1);
            chk("bp bit",   m_out_bit,   ebit(8'h3C, b, 1'b1));
            chk("bp first", m_out_first, (b == 0));
            chk("bp last",  m_out_last,  (b == B8 - 1));
            chk("bp rdy",   m_in_ready,  (ordy && b == B8 - 1));
            if (prev_stall) chk("bp stable", m_out_bit, prev_bit);
            prev_bit = m_out_bit;
            prev_stall = !ordy;
            tick();
            if (ordy) b++;
            c++;
        end
        chk("bp beats", b, B8);
        m_out_ready = 1'b1;
        chk("bp idle valid", m_out_valid, 1'b0);
        chk("bp idle busy",  m_busy,      1'b0);

        // ---- WIDTH=1: word 1 then word 0 back-to-back ----
        s_in_data = 1'b1; s_in_valid = 1'b1;
        tick();
        s_in_data = 1'b0;
        for (int i = 0; i < B1; i++) begin
            chk("w1 valid", s_out_valid, 1'b1);
            chk("w1 bit",   s_out_bit,   1'b1);   // data 1, parity of 1 is also 1
            chk("w1 first", s_out_first, (i == 0));
            chk("w1 last",  s_out_last,  (i == B1 - 1));
            chk("w1 rdy",   s_in_ready,  (i == B1 - 1));
            tick();
        end
        s_in_valid = 1'b0;
        for (int i = 0; i < B1; i++) begin
            chk("w0 valid", s_out_valid, 1'b1);
            chk("w0 bit",   s_out_bit,   1'b0);
            chk("w0 first", s_out_first, (i == 0));
            chk("w0 last",  s_out_last,  (i == B1 - 1));
            tick();
        end
        chk("w1 idle valid", s_out_valid, 1'b0);
        chk("w1 idle busy",  s_busy,      1'b0);

        // ---- reset mid-word ----
        m_in_data = 8'hA5; m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        tick();
        tick();
        chk("mid busy before rst", m_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", m_out_valid, 1'b0);
        chk("mid rst bit",   m_out_bit,   1'b0);
        chk("mid rst first", m_out_first, 1'b0);
        chk("mid rst last",  m_out_last,  1'b0);
        chk("mid rst busy",  m_busy,      1'b0);
        chk("mid rst rdy",   m_in_ready,  1'b0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("post rst rdy",   m_in_ready,  1'b1);
        chk("post rst valid", m_out_valid, 1'b0);
        chk("post rst last",  m_out_last,  1'b0);
        tick();
        chk("post rst still idle", m_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
